// File: rtl/route_net_pkg.sv
// route_net shared helpers: clog2 and derived widths.
// Used by route_net and route_net_switch.
package route_net_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int rn_ports(input int rl2, input int layers);
    return 1 << (rl2 * layers);
  endfunction

  function automatic int rn_tag_w(input int nw, input int rl2, input int layers);
    return nw - rl2 * layers;
  endfunction

  // Width of the word stored after layer l strips its digit.
  // l = -1 gives the full source word.
  function automatic int rn_word_w(
    input int pw,
    input int nw,
    input int rl2,
    input int l
  );
    return pw + nw - (l + 1) * rl2;
  endfunction

endpackage

// File: rtl/route_net_switch.sv
// route_net_switch: R-in/R-out switch, one FIFO plus round-robin arbiter per output.
// Ports: i_vld/i_data/o_ack (inputs, digit in MSBs), o_vld/o_data/i_pop (FIFO heads).
module route_net_switch
  import route_net_pkg::*;
#(
  parameter int RADIX_LOG2 = 3,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int R = 1 << RADIX_LOG2,
  localparam int IW = DATA_WIDTH + RADIX_LOG2,
  localparam int AW = clog2(FIFO_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [R-1:0]                 i_vld,
  input  logic [R-1:0][IW-1:0]         i_data,
  output logic [R-1:0]                 o_ack,
  output logic [R-1:0]                 o_vld,
  output logic [R-1:0][DATA_WIDTH-1:0] o_data,
  input  logic [R-1:0]                 i_pop
);

  logic [R-1:0][R-1:0] w_gnt_all;

  for (genvar d = 0; d < R; d++) begin : g_out
    logic [R-1:0]            w_req;
    logic [R-1:0]            w_gnt;
    logic [RADIX_LOG2-1:0]   w_idx;
    logic [RADIX_LOG2-1:0]   w_nxt;
    logic                    w_found;
    logic                    w_full;
    logic                    w_push;
    logic                    w_pop;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [RADIX_LOG2-1:0]   r_ptr;
    logic [AW-1:0]           r_wr;
    logic [AW-1:0]           r_rd;
    logic [AW:0]             r_cnt;
    logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];

    assign w_full = (r_cnt == (AW+1)'(FIFO_DEPTH));

    // Scan from the pointer; a full FIFO (or reset) grants nobody,
    // so the pointer only advances on a real write.
    always_comb begin
      w_req   = '0;
      w_gnt   = '0;
      w_idx   = '0;
      w_nxt   = r_ptr;
      w_found = 1'b0;
      w_wdata = '0;
      for (int i = 0; i < R; i++) begin
        w_req[i] = i_vld[i] &&
          (i_data[i][IW-1 -: RADIX_LOG2] == RADIX_LOG2'(d));
      end
      for (int k = 0; k < R; k++) begin
        w_idx = r_ptr + RADIX_LOG2'(k);
        if (rst && !w_full && !w_found && w_req[w_idx]) begin
          w_found      = 1'b1;
          w_gnt[w_idx] = 1'b1;
          w_nxt        = w_idx + RADIX_LOG2'(1);
        end
      end
      for (int i = 0; i < R; i++) begin
        if (w_gnt[i]) w_wdata = i_data[i][DATA_WIDTH-1:0];
      end
    end

    assign w_push       = w_found;
    assign w_pop        = i_pop[d] && (r_cnt != '0);
    assign w_gnt_all[d] = w_gnt;
    assign o_vld[d]     = (r_cnt != '0);
    assign o_data[d]    = r_mem[r_rd];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_ptr <= '0;
        r_wr  <= '0;
        r_rd  <= '0;
        r_cnt <= '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
          r_mem[k] <= '0;
        end
      end else begin
        if (w_push) begin
          r_mem[r_wr] <= w_wdata;
          r_wr        <= r_wr + AW'(1);
          r_ptr       <= w_nxt;
        end
        if (w_pop) r_rd <= r_rd + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
          2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  always_comb begin
    o_ack = '0;
    for (int i = 0; i < R; i++) begin
      for (int d = 0; d < R; d++) begin
        o_ack[i] = o_ack[i] | w_gnt_all[d][i];
      end
    end
  end

endmodule

// File: rtl/route_net.sv
// route_net: LAYERS-deep radix-2^RADIX_LOG2 destination-tag routing network.
// Ports: i_req_* sources (o_req_ack back), o_req_* sinks (i_req_ack pops).
// Optional o_blocked_cnt per source when ROUTE_NET_STATS_EN is defined.
module route_net
  import route_net_pkg::*;
#(
  parameter int RADIX_LOG2    = 3,
  parameter int LAYERS        = 2,
  parameter int PAYLOAD_WIDTH = 16,
  parameter int NODENUM_WIDTH = 12,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_WIDTH     = 16,
  localparam int PORTS = rn_ports(RADIX_LOG2, LAYERS),
  localparam int NODETAG_WIDTH =
    rn_tag_w(NODENUM_WIDTH, RADIX_LOG2, LAYERS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PORTS-1:0]                    i_req_vld,
  input  logic [PORTS-1:0][PAYLOAD_WIDTH-1:0] i_req_payload,
  input  logic [PORTS-1:0][NODENUM_WIDTH-1:0] i_req_nodenum,
  output logic [PORTS-1:0]                    o_req_ack,
  output logic [PORTS-1:0]                    o_req_vld,
  output logic [PORTS-1:0][PAYLOAD_WIDTH-1:0] o_req_payload,
  output logic [PORTS-1:0][NODETAG_WIDTH-1:0] o_req_nodetag,
`ifdef ROUTE_NET_STATS_EN
  output logic [PORTS-1:0][CNT_WIDTH-1:0]     o_blocked_cnt,
`endif
  input  logic [PORTS-1:0]                    i_req_ack
);

  localparam int R   = 1 << RADIX_LOG2;
  localparam int NSW = PORTS / R;

  if (NODENUM_WIDTH <= LAYERS * RADIX_LOG2 || CNT_WIDTH < 1 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_bad_cfg
    $error("route_net: illegal parameter set");
  end

  for (genvar l = 0; l < LAYERS; l++) begin : g_layer
    localparam int IW =
      rn_word_w(PAYLOAD_WIDTH, NODENUM_WIDTH, RADIX_LOG2, l - 1);
    localparam int OW =
      rn_word_w(PAYLOAD_WIDTH, NODENUM_WIDTH, RADIX_LOG2, l);

    logic [PORTS-1:0]         w_in_vld;
    logic [PORTS-1:0]         w_in_ack;
    logic [PORTS-1:0][IW-1:0] w_in_data;
    logic [PORTS-1:0]         w_out_vld;
    logic [PORTS-1:0]         w_out_pop;
    logic [PORTS-1:0][OW-1:0] w_out_data;

    // Word layout is {remaining nodenum, payload}; the next
    // routing digit always sits in the MSBs.
    if (l == 0) begin : g_src
      for (genvar j = 0; j < PORTS; j++) begin : g_p
        assign w_in_data[j] = {i_req_nodenum[j], i_req_payload[j]};
      end
      assign w_in_vld = i_req_vld;
    end else begin : g_src
      assign w_in_vld  = g_layer[l-1].w_out_vld;
      assign w_in_data = g_layer[l-1].w_out_data;
    end

    if (l == LAYERS - 1) begin : g_snk
      assign w_out_pop = i_req_ack;
    end else begin : g_snk
      assign w_out_pop = g_layer[l+1].w_in_ack;
    end

    for (genvar g = 0; g < NSW; g++) begin : g_sw
      logic [R-1:0]         w_vld;
      logic [R-1:0]         w_ack;
      logic [R-1:0][IW-1:0] w_dat;
      logic [R-1:0]         w_ovld;
      logic [R-1:0]         w_pop;
      logic [R-1:0][OW-1:0] w_odat;

      // Input i takes index g + i*NSW; FIFO d feeds index R*g + d.
      for (genvar i = 0; i < R; i++) begin : g_i
        assign w_vld[i]                  = w_in_vld[g + i*NSW];
        assign w_dat[i]                  = w_in_data[g + i*NSW];
        assign w_in_ack[g + i*NSW]       = w_ack[i];
        assign w_out_vld[R*g + i]        = w_ovld[i];
        assign w_out_data[R*g + i]       = w_odat[i];
        assign w_pop[i]                  = w_out_pop[R*g + i];
      end

      route_net_switch #(
        .RADIX_LOG2 (RADIX_LOG2),
        .DATA_WIDTH (OW),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_sw (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (w_vld),
        .i_data (w_dat),
        .o_ack  (w_ack),
        .o_vld  (w_ovld),
        .o_data (w_odat),
        .i_pop  (w_pop)
      );
    end
  end

  assign o_req_ack = g_layer[0].w_in_ack;
  assign o_req_vld = g_layer[LAYERS-1].w_out_vld;

  for (genvar j = 0; j < PORTS; j++) begin : g_o
    assign o_req_payload[j] =
      g_layer[LAYERS-1].w_out_data[j][PAYLOAD_WIDTH-1:0];
    assign o_req_nodetag[j] =
      g_layer[LAYERS-1].w_out_data[j][PAYLOAD_WIDTH +: NODETAG_WIDTH];
  end

`ifdef ROUTE_NET_STATS_EN
  logic [PORTS-1:0][CNT_WIDTH-1:0] r_blk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blk <= '0;
    end else begin
      for (int j = 0; j < PORTS; j++) begin
        if (i_req_vld[j] && !o_req_ack[j] && (r_blk[j] != '1)) begin
          r_blk[j] <= r_blk[j] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign o_blocked_cnt = r_blk;
`endif

endmodule

// File: tb/tb_route_net.sv
// tb_route_net: directed stimulus with a per-output scoreboard
// for route_net at RADIX_LOG2=2, LAYERS=2, PAYLOAD 8, NODENUM 6, FIFO 2.
module tb_route_net;

  localparam int P  = 16;
  localparam int PW = 8;
  localparam int NW = 6;
  localparam int TW = 2;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [P-1:0]         i_req_vld;
  logic [P-1:0][PW-1:0] i_req_payload;
  logic [P-1:0][NW-1:0] i_req_nodenum;
  logic [P-1:0]         o_req_ack;
  logic [P-1:0]         o_req_vld;
  logic [P-1:0][PW-1:0] o_req_payload;
  logic [P-1:0][TW-1:0] o_req_nodetag;
  logic [P-1:0]         i_req_ack;
`ifdef ROUTE_NET_STATS_EN
  logic [P-1:0][CW-1:0] o_blocked_cnt;
`endif

  typedef struct {
    logic [PW-1:0] pl;
    logic [TW-1:0] tag;
    int            cyc;
    bit            exact;
  } exp_t;

  exp_t sb [P][$];
  exp_t m_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   exact_mode = 1'b1;
  logic [P-1:0] last_ack;

  route_net #(
    .RADIX_LOG2    (2),
    .LAYERS        (2),
    .PAYLOAD_WIDTH (PW),
    .NODENUM_WIDTH (NW),
    .FIFO_DEPTH    (2),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_vld     (i_req_vld),
    .i_req_payload (i_req_payload),
    .i_req_nodenum (i_req_nodenum),
    .o_req_ack     (o_req_ack),
    .o_req_vld     (o_req_vld),
    .o_req_payload (o_req_payload),
    .o_req_nodetag (o_req_nodetag),
`ifdef ROUTE_NET_STATS_EN
    .o_blocked_cnt (o_blocked_cnt),
`endif
    .i_req_ack     (i_req_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, want finish");
    $fatal(1);
  end

  // Monitor: pop the expected head whenever an output is popped.
  always @(negedge clk) begin
    if (rst) begin
      for (int j = 0; j < P; j++) begin
        if (o_req_vld[j] && sb[j].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out%0d unexpected: got pl=%h tag=%h, want none",
                   j, o_req_payload[j], o_req_nodetag[j]);
        end else if (o_req_vld[j] && i_req_ack[j]) begin
          m_e = sb[j].pop_front();
          checks++;
          if (o_req_payload[j] !== m_e.pl ||
              o_req_nodetag[j] !== m_e.tag ||
              (m_e.exact && cyc != m_e.cyc)) begin
            errors++;
            $display("FAIL out%0d: got pl=%h tag=%h cyc=%0d, want pl=%h tag=%h cyc=%0d",
                     j, o_req_payload[j], o_req_nodetag[j], cyc,
                     m_e.pl, m_e.tag, m_e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", n, got, want);
    end
  endtask

  // Mid-cycle: record accepted requests and predict their delivery.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    last_ack = i_req_vld & o_req_ack;
    for (int j = 0; j < P; j++) begin
      if (last_ack[j]) begin
        e.pl    = i_req_payload[j];
        e.tag   = i_req_nodenum[j][1:0];
        e.cyc   = cyc + 2;
        e.exact = exact_mode;
        sb[i_req_nodenum[j][5:2]].push_back(e);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic int pending();
    int n;
    n = 0;
    for (int j = 0; j < P; j++) n += sb[j].size();
    return n;
  endfunction

  task automatic drain(input string n);
    for (int c = 0; c < 30; c++) begin
      if (pending() == 0) break;
      sample();
      adv();
    end
    chk(n, 64'(pending()), 64'd0);
  endtask

  initial begin
    int ord [4];
    int acc;
    i_req_vld     = '0;
    i_req_payload = '0;
    i_req_nodenum = '0;
    i_req_ack     = '1;
    last_ack      = '0;
    ord = '{0, 4, 8, 12};

    // Reset state, with a live request that must not be acked.
    i_req_vld[2]     = 1'b1;
    i_req_nodenum[2] = 6'b0011_01;
    @(negedge clk);
    chk("rst_vld", 64'(o_req_vld), 64'd0);
    chk("rst_ack", 64'(o_req_ack), 64'd0);
    chk("rst_pl", 64'(|o_req_payload), 64'd0);
    chk("rst_tag", 64'(|o_req_nodetag), 64'd0);
`ifdef ROUTE_NET_STATS_EN
    chk("rst_cnt", 64'(|o_blocked_cnt), 64'd0);
`endif
    i_req_vld = '0;
    adv();
    rst = 1'b1;
    adv();

    // Single request: port 3 -> output 9, tag 3.
    i_req_vld[3]     = 1'b1;
    i_req_nodenum[3] = 6'b10_01_11;
    i_req_payload[3] = 8'hA5;
    sample();
    chk("single_ack", 64'(o_req_ack), 64'h0008);
    adv();
    i_req_vld = '0;
    drain("single_drain");

    // Contention: four sources on output 5, served in RR order.
    for (int k = 0; k < 4; k++) begin
      i_req_vld[ord[k]]     = 1'b1;
      i_req_nodenum[ord[k]] = {4'b0101, 2'(k)};
      i_req_payload[ord[k]] = 8'(8'h10 + k);
    end
    for (int k = 0; k < 4; k++) begin
      sample();
      chk($sformatf("cont_ack%0d", k), 64'(o_req_ack), 64'(1 << ord[k]));
      adv();
      i_req_vld = i_req_vld & ~last_ack;
    end
    i_req_vld = '0;
`ifdef ROUTE_NET_STATS_EN
    chk("cnt0", 64'(o_blocked_cnt[0]), 64'd0);
    chk("cnt4", 64'(o_blocked_cnt[4]), 64'd1);
    chk("cnt8", 64'(o_blocked_cnt[8]), 64'd2);
    chk("cnt12", 64'(o_blocked_cnt[12]), 64'd3);
`endif
    drain("cont_drain");

    // Backpressure: output 5 stalled while port 1 streams to it.
    exact_mode       = 1'b0;
    i_req_ack[5]     = 1'b0;
    i_req_vld[1]     = 1'b1;
    i_req_nodenum[1] = 6'b0101_10;
    i_req_payload[1] = 8'h40;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      sample();
      if (c == 7) chk("bp_stall", 64'(o_req_ack[1]), 64'd0);
      adv();
      if (last_ack[1]) begin
        acc++;
        i_req_payload[1] = i_req_payload[1] + 8'd1;
      end
    end
    chk("bp_accepts", 64'(acc), 64'd4);
    i_req_ack[5] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      sample();
      adv();
      if (last_ack[1]) begin
        acc++;
        i_req_payload[1] = i_req_payload[1] + 8'd1;
      end
    end
    chk("bp_resume", 64'(acc > 4), 64'd1);
    i_req_vld = '0;
    drain("bp_drain");
    exact_mode = 1'b1;

    // Identity permutation for 20 cycles, every port acked each cycle.
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < P; j++) begin
        i_req_vld[j]     = 1'b1;
        i_req_nodenum[j] = {4'(j), 2'(j)};
        i_req_payload[j] = 8'(j + 3 * k);
      end
      sample();
      chk($sformatf("ident_ack%0d", k), 64'(o_req_ack), 64'hFFFF);
      adv();
    end
    i_req_vld = '0;
    drain("ident_drain");

    // Reset mid-operation with data held in the FIFOs.
    i_req_ack = '0;
    for (int j = 0; j < 4; j++) begin
      i_req_vld[j]     = 1'b1;
      i_req_nodenum[j] = {4'(j + 7), 2'b01};
      i_req_payload[j] = 8'(8'h80 + j);
    end
    for (int c = 0; c < 3; c++) begin
      sample();
      adv();
    end
    i_req_vld = '0;
    chk("pre_rst_vld", 64'(o_req_vld != '0), 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst_vld", 64'(o_req_vld), 64'd0);
    for (int j = 0; j < P; j++) sb[j].delete();
    adv();
    adv();
    rst = 1'b1;
    i_req_ack = '1;
    for (int c = 0; c < 4; c++) begin
      sample();
      adv();
    end
    i_req_vld[6]     = 1'b1;
    i_req_nodenum[6] = 6'b0010_01;
    i_req_payload[6] = 8'h5A;
    sample();
    chk("post_rst_ack", 64'(o_req_ack), 64'h0040);
    adv();
    i_req_vld = '0;
    drain("post_rst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
